// File: rtl/arb_weight_credit_tracker_pkg.sv
// arb_weight_credit_tracker_pkg: shared state encoding and packing helpers for the weighted arbiter.
// Contents: state_e (S_LOAD/S_ACTIVE), P_WEIGHT_W_DEF, slice_hi() giving the top index of
// requester n's field inside a [0:N*W-1] packed vector.
package arb_weight_credit_tracker_pkg;
  localparam int unsigned P_WEIGHT_W_DEF = 2;
  typedef enum logic {S_LOAD = 1'b0, S_ACTIVE = 1'b1} state_e;
  function automatic int unsigned slice_hi(input int unsigned n, input int unsigned w);
    return (n + 1) * w - 1;
  endfunction
endpackage

// File: rtl/arb_credit_counter.sv
// arb_credit_counter: W-bit saturating down-counter holding one requester's grant credit.
// Ports: clk_i/rst_i (async active-high), load_i + load_val_i reload the credit (load wins),
// dec_i consumes one credit unless already 0, credit_o current count, remain_o = credit != 0.
module arb_credit_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] credit_o,
  output logic         remain_o
);
  logic [W-1:0] credit_q, credit_d;
  always_comb begin
    credit_d = load_i ? load_val_i : (dec_i && credit_q != '0) ? credit_q - W'(1) : credit_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) credit_q <= '0;
    else       credit_q <= credit_d;
  end
  assign credit_o = credit_q;
  assign remain_o = credit_q != '0;
endmodule

// File: rtl/arb_weight_credit_tracker.sv
// arb_weight_credit_tracker: per-requester grant credit bookkeeping for a weighted round-robin arbiter.
// Ports: ACLK_i/ARESET_i (async active-high); req_weight_i packed weights [0:N*W-1], requester n at
// bits ((n+1)*W-1)-:W; req_i requests; grant_i one-hot grant; grant_accept_i handshake done;
// round_comp_i round complete; req_weight_remain_o credit!=0 flags; eligible_o grantable requests;
// round_start_o pulse when fresh credits are active; credit_o packed credits (same layout as weights).
// Build option: define ARB_WORK_CONSERVING_EN to present all requests as eligible in the
// exhaustion cycle instead of inserting a one-cycle arbitration bubble.
module arb_weight_credit_tracker
  import arb_weight_credit_tracker_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = 3,
  parameter int unsigned P_WEIGHT_W      = P_WEIGHT_W_DEF
) (
  input  logic                                ACLK_i,
  input  logic                                ARESET_i,
  input  logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_weight_i,
  input  logic [P_REQUESTER_NUM-1:0]          req_i,
  input  logic [P_REQUESTER_NUM-1:0]          grant_i,
  input  logic                                grant_accept_i,
  input  logic                                round_comp_i,
  output logic [P_REQUESTER_NUM-1:0]          req_weight_remain_o,
  output logic [P_REQUESTER_NUM-1:0]          eligible_o,
  output logic                                round_start_o,
  output logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] credit_o
);
  state_e                       state_q, state_d;
  logic [P_REQUESTER_NUM-1:0]   remain, dec;
  logic                         exhaust, reload, load, round_start_q, round_start_d;
  always_comb begin
    exhaust       = (state_q == S_ACTIVE) && (|req_i) && !(|(req_i & remain));
    reload        = (state_q == S_ACTIVE) && (round_comp_i || exhaust);
    load          = (state_q == S_LOAD) || reload;
    state_d       = (state_q == S_LOAD) ? S_ACTIVE : state_q;
    round_start_d = load;
    // only the lowest set grant bit is charged; a reload overrides it inside the counter
    dec           = grant_accept_i ? (grant_i & (-grant_i)) : '0;
  end
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      state_q       <= S_LOAD;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_start_q <= round_start_d;
    end
  end
  for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_cc
    arb_credit_counter #(.W(P_WEIGHT_W)) u_cc (
      .clk_i      (ACLK_i),
      .rst_i      (ARESET_i),
      .load_i     (load),
      .load_val_i (req_weight_i[slice_hi(i, P_WEIGHT_W) -: P_WEIGHT_W]),
      .dec_i      (dec[i]),
      .credit_o   (credit_o[slice_hi(i, P_WEIGHT_W) -: P_WEIGHT_W]),
      .remain_o   (remain[i])
    );
  end
  assign req_weight_remain_o = remain;
  assign round_start_o       = round_start_q;
`ifdef ARB_WORK_CONSERVING_EN
  assign eligible_o = exhaust ? req_i : (req_i & remain);
`else
  assign eligible_o = exhaust ? '0 : (req_i & remain);
`endif
endmodule
